// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one asynchronous 48-bit SRAM between a CPU (low 32-bit
// lane), a video writer (high 16-bit lane) and a video scan-out reader.
// Even cycles are access slots for the granted requester; odd cycles are
// scan slots that always read vram_scan_addr. Lane writes are done as
// read-modify-write so the other lane of the word is preserved.
module sram_arbiter #(
   parameter int ADDR_W = 20,
   parameter int DATA_W = 48
) (
   input  logic              clk_50mhz,
   input  logic              rst,
   // CPU port (32-bit lane, bits 31:0)
   input  logic              r_stb,
   input  logic              r_we,
   input  logic [ADDR_W-1:0] r_addr,
   input  logic [31:0]       r_din,
   output logic [31:0]       r_dout,
   output logic              r_ack,
   // video writer port (16-bit lane, bits 47:32)
   input  logic              v_stb,
   input  logic              v_we,
   input  logic [ADDR_W-1:0] v_addr,
   input  logic [15:0]       v_din,
   output logic [15:0]       v_dout,
   output logic              v_ack,
   // scan-out read port
   input  logic [ADDR_W-1:0] vram_scan_addr,
   output logic [15:0]       vram_scan_data,
   // SRAM pins; the top level builds the inout bus from DQ_O/DQ_OE/DQ_I
   output logic [ADDR_W-1:0] SRAM_ADDR,
   output logic              SRAM_CE,
   output logic              SRAM_OEN,
   output logic              SRAM_WEN,
   output logic [DATA_W-1:0] SRAM_DQ_O,
   output logic              SRAM_DQ_OE,
   input  logic [DATA_W-1:0] SRAM_DQ_I
);

   typedef enum logic [2:0] {IDLE, RD, WAIT, WR, ACK} state_t;

   localparam logic ID_CPU = 1'b0;
   localparam logic ID_VID = 1'b1;

   state_t            r_state;
   state_t            w_state_next;
   logic              r_phase;        // 1 = scan slot, 0 = access slot
   logic              r_last_grant;   // requester served most recently
   logic              r_id;           // requester owning the current access
   logic              r_we_lat;
   logic [ADDR_W-1:0] r_addr_lat;
   logic [31:0]       r_wdata_lat;    // video data sits in the low 16 bits
   logic [DATA_W-1:0] r_rd_buf;
   logic [15:0]       r_scan_data;
   logic              r_cpu_ack;
   logic              r_vid_ack;

   logic              w_cpu_req;
   logic              w_vid_req;
   logic              w_grant_vid;
   logic              w_grant;
   logic [DATA_W-1:0] w_wdata;

   // Round-robin arbitration; a requester being acked this cycle is ignored
   always_comb begin
      w_cpu_req   = r_stb & ~r_cpu_ack;
      w_vid_req   = v_stb & ~r_vid_ack;
      w_grant_vid = w_vid_req & (~w_cpu_req | (r_last_grant == ID_CPU));
      w_grant     = r_phase & (r_state == IDLE) & (w_cpu_req | w_vid_req);
   end

   // Merge the requester's lane into the word fetched during RD
   assign w_wdata = (r_id == ID_CPU) ? {r_rd_buf[47:32], r_wdata_lat}
                                     : {r_wdata_lat[15:0], r_rd_buf[31:0]};

   assign SRAM_CE        = 1'b0;
   assign SRAM_DQ_O      = w_wdata;
   assign r_ack          = r_cpu_ack;
   assign v_ack          = r_vid_ack;
   assign r_dout         = r_rd_buf[31:0];
   assign v_dout         = r_rd_buf[47:32];
   assign vram_scan_data = r_scan_data;

   // FSM state register
   always_ff @(posedge clk_50mhz) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // FSM next state and SRAM control decode (scan slots override access)
   always_comb begin
      w_state_next = r_state;
      SRAM_ADDR    = r_addr_lat;
      SRAM_OEN     = 1'b1;
      SRAM_WEN     = 1'b1;
      SRAM_DQ_OE   = 1'b0;
      case (r_state)
         IDLE:    if (w_grant) w_state_next = RD;
         RD:      w_state_next = r_we_lat ? WAIT : ACK;
         WAIT:    w_state_next = WR;
         WR:      w_state_next = ACK;
         ACK:     w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
      if (r_phase) begin
         SRAM_ADDR = vram_scan_addr;
         SRAM_OEN  = 1'b0;
      end else if (r_state == RD) begin
         SRAM_OEN = 1'b0;
      end else if (r_state == WR) begin
         SRAM_WEN   = 1'b0;
         SRAM_DQ_OE = 1'b1;
      end
   end

   // Slot phase, request latching, read capture and one-cycle acks
   always_ff @(posedge clk_50mhz) begin
      if (rst) begin
         r_phase      <= 1'b0;
         r_last_grant <= ID_VID;
         r_id         <= ID_CPU;
         r_we_lat     <= 1'b0;
         r_addr_lat   <= '0;
         r_wdata_lat  <= '0;
         r_rd_buf     <= '0;
         r_scan_data  <= '0;
         r_cpu_ack    <= 1'b0;
         r_vid_ack    <= 1'b0;
      end else begin
         r_phase <= ~r_phase;
         if (r_phase) begin
            r_scan_data <= SRAM_DQ_I[47:32];
         end
         if (r_state == RD) begin
            r_rd_buf <= SRAM_DQ_I;
         end
         if (w_grant) begin
            r_id         <= w_grant_vid;
            r_last_grant <= w_grant_vid;
            r_addr_lat   <= w_grant_vid ? v_addr : r_addr;
            r_wdata_lat  <= w_grant_vid ? {16'd0, v_din} : r_din;
            r_we_lat     <= w_grant_vid ? v_we : r_we;
         end
         // ACK is only ever entered for a single cycle
         r_cpu_ack <= (w_state_next == ACK) && (r_id == ID_CPU);
         r_vid_ack <= (w_state_next == ACK) && (r_id == ID_VID);
      end
   end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: behavioural SRAM, requester drivers and a
// scoreboard of expected acks in grant order.
module tb_sram_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        r_stb = 1'b0, r_we = 1'b0, v_stb = 1'b0, v_we = 1'b0;
   logic [19:0] r_addr = '0, v_addr = '0;
   logic [31:0] r_din = '0;
   logic [15:0] v_din = '0;
   logic [31:0] r_dout;
   logic [15:0] v_dout, vram_scan_data;
   logic        r_ack, v_ack;
   logic [19:0] vram_scan_addr = 20'h00020;
   logic [19:0] sram_addr;
   logic        sram_ce, sram_oen, sram_wen, sram_dq_oe;
   logic [47:0] sram_dq_o, sram_dq_i;

   always #10 clk = ~clk;

   sram_arbiter #(.ADDR_W(20), .DATA_W(48)) dut (
      .clk_50mhz(clk), .rst(rst),
      .r_stb(r_stb), .r_we(r_we), .r_addr(r_addr), .r_din(r_din), .r_dout(r_dout), .r_ack(r_ack),
      .v_stb(v_stb), .v_we(v_we), .v_addr(v_addr), .v_din(v_din), .v_dout(v_dout), .v_ack(v_ack),
      .vram_scan_addr(vram_scan_addr), .vram_scan_data(vram_scan_data),
      .SRAM_ADDR(sram_addr), .SRAM_CE(sram_ce), .SRAM_OEN(sram_oen), .SRAM_WEN(sram_wen),
      .SRAM_DQ_O(sram_dq_o), .SRAM_DQ_OE(sram_dq_oe), .SRAM_DQ_I(sram_dq_i)
   );

   // Behavioural SRAM (low 8 address bits decoded), plus a preload port
   logic [47:0] mem [0:255];
   logic        poke = 1'b0;
   logic [7:0]  poke_addr = '0;
   logic [47:0] poke_data = '0;
   assign sram_dq_i = mem[sram_addr[7:0]];
   always @(posedge clk) begin
      if (poke) mem[poke_addr] <= poke_data;
      else if (!sram_wen && sram_dq_oe && !sram_ce) mem[sram_addr[7:0]] <= sram_dq_o;
   end

   // Expected slot phase: reset to access slot, then alternate
   bit tb_phase = 1'b0;
   always @(posedge clk) tb_phase <= rst ? 1'b0 : ~tb_phase;

   typedef struct packed { bit vid; bit we; logic [19:0] addr; logic [31:0] wdata; } tx_t;
   typedef struct { bit vid; bit chk; logic [19:0] addr; logic [31:0] rdata; int lat; int wen; } exp_t;
   typedef struct { bit vid; logic [19:0] addr; logic [31:0] rdata; int lat; int wen; } obs_t;

   tx_t         cpu_q[$], vid_q[$];
   exp_t        exp_q[$];
   obs_t        obs_q[$];
   logic [15:0] scan_q[$];
   int          scan_wen_bad = 0;
   int          total = 0, bad = 0;

   task automatic preset(input logic [7:0] a, input logic [47:0] d);
      poke_addr = a; poke_data = d; poke = 1'b1;
      @(posedge clk); #1;
      poke = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1; r_stb = 1'b0; v_stb = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      cpu_q.delete(); vid_q.delete(); exp_q.delete(); obs_q.delete();
   endtask

   // Queue a transaction and its expected ack; call in expected grant order
   task automatic push_tx(input bit vid, input bit we, input logic [19:0] a,
                          input logic [31:0] wd, input logic [31:0] rd);
      tx_t t;
      t = '{vid: vid, we: we, addr: a, wdata: wd};
      if (vid) vid_q.push_back(t); else cpu_q.push_back(t);
      exp_q.push_back('{vid: vid, chk: !we, addr: a, rdata: rd, lat: we ? 4 : 2, wen: we ? 1 : 0});
   endtask

   // Drive both requesters until their queues drain; log each ack
   task automatic run_traffic(input int budget);
      bit          c_on = 0, v_on = 0, c_gap = 0, v_gap = 0, seen_scan = 0;
      tx_t         c_tx = '0, v_tx = '0;
      int          rd_cyc = -100, wen_cnt = 0;
      logic [19:0] rd_addr = '0;
      scan_q.delete();
      scan_wen_bad = 0;
      for (int k = 0; k < budget; k++) begin
         if (!c_on && !c_gap && cpu_q.size() > 0) begin c_tx = cpu_q.pop_front(); c_on = 1; end
         if (!v_on && !v_gap && vid_q.size() > 0) begin v_tx = vid_q.pop_front(); v_on = 1; end
         r_stb = c_on; r_we = c_tx.we; r_addr = c_tx.addr; r_din = c_tx.wdata;
         v_stb = v_on; v_we = v_tx.we; v_addr = v_tx.addr; v_din = v_tx.wdata[15:0];
         @(negedge clk);
         if (!tb_phase && !sram_oen) begin rd_cyc = k; rd_addr = sram_addr; end
         if (!sram_wen) begin wen_cnt++; if (tb_phase) scan_wen_bad++; end
         if (!tb_phase && seen_scan) scan_q.push_back(vram_scan_data);
         if (tb_phase) seen_scan = 1;
         c_gap = 0; v_gap = 0;
         if (r_ack) begin
            obs_q.push_back('{vid: 1'b0, addr: rd_addr, rdata: r_dout, lat: k - rd_cyc + 1, wen: wen_cnt});
            $display("cpu ack addr=%h dout=%h lat=%0d wen_cycles=%0d", rd_addr, r_dout, k - rd_cyc + 1, wen_cnt);
            wen_cnt = 0; c_on = 0; c_gap = 1;
         end
         if (v_ack) begin
            obs_q.push_back('{vid: 1'b1, addr: rd_addr, rdata: {16'd0, v_dout}, lat: k - rd_cyc + 1, wen: wen_cnt});
            $display("vid ack addr=%h dout=%h lat=%0d wen_cycles=%0d", rd_addr, v_dout, k - rd_cyc + 1, wen_cnt);
            wen_cnt = 0; v_on = 0; v_gap = 1;
         end
         if (!c_on && !v_on && !c_gap && !v_gap && cpu_q.size() == 0 && vid_q.size() == 0) break;
         @(posedge clk); #1;
      end
      r_stb = 1'b0; v_stb = 1'b0;
      cpu_q.delete(); vid_q.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++; if (sram_wen !== 1'b1) begin bad++; $display("FAIL reset_wen: got %b want 1", sram_wen); end
      total++; if (sram_oen !== 1'b1) begin bad++; $display("FAIL reset_oen: got %b want 1", sram_oen); end
      total++; if (sram_dq_oe !== 1'b0) begin bad++; $display("FAIL reset_dq_oe: got %b want 0", sram_dq_oe); end
      total++; if (sram_ce !== 1'b0) begin bad++; $display("FAIL reset_ce: got %b want 0", sram_ce); end
      total++; if (r_ack !== 1'b0) begin bad++; $display("FAIL reset_r_ack: got %b want 0", r_ack); end
      total++; if (v_ack !== 1'b0) begin bad++; $display("FAIL reset_v_ack: got %b want 0", v_ack); end
      total++; if (vram_scan_data !== 16'h0) begin bad++; $display("FAIL reset_scan: got %h want 0000", vram_scan_data); end
      total++; if (r_dout !== 32'h0) begin bad++; $display("FAIL reset_r_dout: got %h want 0", r_dout); end
      total++; if (v_dout !== 16'h0) begin bad++; $display("FAIL reset_v_dout: got %h want 0", v_dout); end
      @(posedge clk); #1 rst = 1'b0;
   endtask

   task automatic test_cpu_read();
      exp_t e; obs_t o;
      do_reset();
      preset(8'h10, 48'hABCD_1234_5678);
      preset(8'hF0, 48'h0F0F_DEAD_BEEF);
      push_tx(1'b0, 1'b0, 20'h00010, 32'h0, 32'h1234_5678);
      push_tx(1'b1, 1'b0, 20'h00010, 32'h0, 32'h0000_ABCD);
      push_tx(1'b0, 1'b0, 20'hFFFF0, 32'h0, 32'hDEAD_BEEF);
      run_traffic(200);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total++;
         if (obs_q.size() == 0) begin bad++; $display("FAIL read_ack: got no ack, want vid=%0b addr=%h", e.vid, e.addr); end
         else begin
            o = obs_q.pop_front();
            total++;
            if (o.vid !== e.vid || o.addr !== e.addr || o.lat != e.lat || o.wen != e.wen || (e.chk && o.rdata !== e.rdata)) begin
               bad++;
               $display("FAIL read_txn: got vid=%0b addr=%h lat=%0d wen=%0d data=%h, want vid=%0b addr=%h lat=%0d wen=%0d data=%h",
                        o.vid, o.addr, o.lat, o.wen, o.rdata, e.vid, e.addr, e.lat, e.wen, e.rdata);
            end
         end
      end
   endtask

   task automatic test_video_write();
      exp_t e; obs_t o;
      do_reset();
      preset(8'h10, 48'hABCD_1234_5678);
      push_tx(1'b1, 1'b1, 20'h00010, 32'h0000_BEEF, 32'h0);
      run_traffic(100);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total++;
         if (obs_q.size() == 0) begin bad++; $display("FAIL vwrite_ack: got no ack, want vid=%0b addr=%h", e.vid, e.addr); end
         else begin
            o = obs_q.pop_front();
            total++;
            if (o.vid !== e.vid || o.addr !== e.addr || o.lat != e.lat || o.wen != e.wen) begin
               bad++;
               $display("FAIL vwrite_txn: got vid=%0b addr=%h lat=%0d wen=%0d, want vid=%0b addr=%h lat=%0d wen=%0d",
                        o.vid, o.addr, o.lat, o.wen, e.vid, e.addr, e.lat, e.wen);
            end
         end
      end
      total++; if (mem[8'h10] !== 48'hBEEF_1234_5678) begin bad++; $display("FAIL vwrite_word: got %h want beef12345678", mem[8'h10]); end
      push_tx(1'b0, 1'b1, 20'h00010, 32'hCAFE_F00D, 32'h0);
      push_tx(1'b0, 1'b0, 20'h00010, 32'h0, 32'hCAFE_F00D);
      run_traffic(100);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total++;
         if (obs_q.size() == 0) begin bad++; $display("FAIL cwrite_ack: got no ack, want vid=%0b addr=%h", e.vid, e.addr); end
         else begin
            o = obs_q.pop_front();
            total++;
            if (o.vid !== e.vid || o.addr !== e.addr || o.lat != e.lat || o.wen != e.wen || (e.chk && o.rdata !== e.rdata)) begin
               bad++;
               $display("FAIL cwrite_txn: got vid=%0b addr=%h lat=%0d wen=%0d data=%h, want vid=%0b addr=%h lat=%0d wen=%0d data=%h",
                        o.vid, o.addr, o.lat, o.wen, o.rdata, e.vid, e.addr, e.lat, e.wen, e.rdata);
            end
         end
      end
      total++; if (mem[8'h10] !== 48'hBEEF_CAFE_F00D) begin bad++; $display("FAIL cwrite_word: got %h want beefcafef00d", mem[8'h10]); end
   endtask

   task automatic test_round_robin();
      exp_t e; obs_t o;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         preset(8'(64 + i), 48'h1000_C0DE_0000 + 48'(i));
         preset(8'(128 + i), 48'h2222_0000_0000 + (48'(i) << 32));
      end
      for (int i = 0; i < 4; i++) begin
         push_tx(1'b0, 1'b0, 20'(64 + i), 32'h0, 32'hC0DE_0000 + 32'(i));
         push_tx(1'b1, 1'b0, 20'(128 + i), 32'h0, 32'h0000_2222 + 32'(i));
      end
      run_traffic(400);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total++;
         if (obs_q.size() == 0) begin bad++; $display("FAIL rr_ack: got no ack, want vid=%0b addr=%h", e.vid, e.addr); end
         else begin
            o = obs_q.pop_front();
            total++;
            if (o.vid !== e.vid || o.addr !== e.addr || o.lat != e.lat || o.wen != e.wen || o.rdata !== e.rdata) begin
               bad++;
               $display("FAIL rr_txn: got vid=%0b addr=%h lat=%0d wen=%0d data=%h, want vid=%0b addr=%h lat=%0d wen=%0d data=%h",
                        o.vid, o.addr, o.lat, o.wen, o.rdata, e.vid, e.addr, e.lat, e.wen, e.rdata);
            end
         end
      end
   endtask

   task automatic test_scan();
      exp_t e; obs_t o;
      do_reset();
      preset(8'h20, 48'h1111_2222_3333);
      for (int i = 0; i < 3; i++) begin
         push_tx(1'b0, 1'b1, 20'(80 + i), 32'h5000_0000 + 32'(i), 32'h0);
         push_tx(1'b1, 1'b1, 20'(96 + i), 32'h0000_6000 + 32'(i), 32'h0);
      end
      run_traffic(400);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total++;
         if (obs_q.size() == 0) begin bad++; $display("FAIL scan_ack: got no ack, want vid=%0b addr=%h", e.vid, e.addr); end
         else begin
            o = obs_q.pop_front();
            total++;
            if (o.vid !== e.vid || o.addr !== e.addr || o.lat != e.lat || o.wen != e.wen) begin
               bad++;
               $display("FAIL scan_txn: got vid=%0b addr=%h lat=%0d wen=%0d, want vid=%0b addr=%h lat=%0d wen=%0d",
                        o.vid, o.addr, o.lat, o.wen, e.vid, e.addr, e.lat, e.wen);
            end
         end
      end
      total++; if (scan_q.size() < 10) begin bad++; $display("FAIL scan_count: got %0d samples want >=10", scan_q.size()); end
      foreach (scan_q[i]) begin
         total++;
         if (scan_q[i] !== 16'h1111) begin bad++; $display("FAIL scan_data[%0d]: got %h want 1111", i, scan_q[i]); end
      end
      total++; if (scan_wen_bad != 0) begin bad++; $display("FAIL scan_wen: got %0d scan-slot WEN lows want 0", scan_wen_bad); end
      total++; if (mem[8'h50] !== 48'h0000_5000_0000 && mem[8'h50][31:0] !== 32'h5000_0000) begin bad++; $display("FAIL scan_wr_word: got %h want xxxx50000000", mem[8'h50]); end
   endtask

   task automatic test_withdraw();
      int accesses = 0, acks = 0;
      do_reset();
      r_addr = 20'h00010; r_we = 1'b0; r_stb = 1'b1;
      @(posedge clk); #1 r_stb = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (!tb_phase && !sram_oen) accesses++;
         if (r_ack || v_ack) acks++;
      end
      total++; if (accesses != 0) begin bad++; $display("FAIL withdraw_access: got %0d accesses want 0", accesses); end
      total++; if (acks != 0) begin bad++; $display("FAIL withdraw_ack: got %0d acks want 0", acks); end
   endtask

   task automatic test_reset_mid_wr();
      bit found = 0;
      int acks = 0;
      do_reset();
      preset(8'h30, 48'h5555_6666_7777);
      r_addr = 20'h00030; r_we = 1'b1; r_din = 32'h1234_5678; r_stb = 1'b1;
      for (int k = 0; k < 20 && !found; k++) begin
         @(negedge clk);
         if (!sram_wen) found = 1;
      end
      total++;
      if (!found) begin
         bad++; $display("FAIL midwr_find: got no WR cycle within 20 cycles, want one");
         r_stb = 1'b0;
      end else begin
         rst = 1'b1;
         @(posedge clk); #1 r_stb = 1'b0;
         @(negedge clk);
         total++; if (sram_wen !== 1'b1) begin bad++; $display("FAIL midwr_wen: got %b want 1", sram_wen); end
         total++; if (sram_oen !== 1'b1) begin bad++; $display("FAIL midwr_oen: got %b want 1", sram_oen); end
         total++; if (sram_dq_oe !== 1'b0) begin bad++; $display("FAIL midwr_dq_oe: got %b want 0", sram_dq_oe); end
         total++; if (r_ack !== 1'b0) begin bad++; $display("FAIL midwr_r_ack: got %b want 0", r_ack); end
         total++; if (vram_scan_data !== 16'h0) begin bad++; $display("FAIL midwr_scan: got %h want 0000", vram_scan_data); end
         total++; if (r_dout !== 32'h0) begin bad++; $display("FAIL midwr_r_dout: got %h want 0", r_dout); end
         @(posedge clk); #1 rst = 1'b0;
         repeat (12) begin
            @(negedge clk);
            if (r_ack) acks++;
         end
         total++; if (acks != 0) begin bad++; $display("FAIL midwr_late_ack: got %0d acks want 0", acks); end
      end
   endtask

   initial begin
      test_reset();
      test_cpu_read();
      test_video_write();
      test_round_robin();
      test_scan();
      test_withdraw();
      test_reset_mid_wr();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1);
   end

endmodule
